raster_mem_sink: RTL and testbench

- Responder end of the raster scanner's memory handshake (`data`, `mem_commit`, `mem_finished`).
- Accepts one ADC sample word per four-phase handshake and sign-extends it to the bus width.
- Writes it into a circular buffer in system RAM through a valid/ready bus write port.
- Tracks fill level against a read pointer owned by the kernel, so the kernel can drain samples to the controller over ethernet.

---
 rtl/raster_pkg.sv | 16 +
 rtl/ring_ptr.sv | 37 +++
 rtl/raster_mem_sink.sv | 129 ++++++++++++
 tb/tb_raster_mem_sink.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared definitions for the raster scanner and its memory sink.
package raster_pkg;

  localparam int STATE_WID        = 2;
  localparam int DEF_DAT_WID      = 24;
  localparam int DEF_BUS_DATA_WID = 32;

  // Sink handshake states
  typedef enum logic [STATE_WID-1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ring_ptr.sv
// Write pointer of a circular buffer plus fill-level compare against an
// externally owned read pointer. One slot is always kept empty so that
// wr_ptr == rd_ptr unambiguously means empty.
module ring_ptr #(
  parameter int PTR_WID = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               inc,
  input  logic [PTR_WID-1:0] rd_ptr,
  output logic [PTR_WID-1:0] wr_ptr,
  output logic [PTR_WID:0]   words_avail,
  output logic               full
);

  logic [PTR_WID-1:0] diff;

  // Fill level is modulo the buffer depth; wrap is implicit in the width
  always_comb begin
    diff        = wr_ptr - rd_ptr;
    words_avail = {1'b0, diff};
    full        = (diff == {PTR_WID{1'b1}});
  end

  // Pointer register; clear takes priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (inc) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/raster_mem_sink.sv
// Responder side of the raster scanner memory handshake. Each sample is
// sign-extended and written into a RAM ring buffer through a valid/ready
// write port; mem_finished is only raised once the bus accepted the word.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for mem_commit; clear is honoured only here
// STALL | commit seen while buffer full; waiting for the kernel to drain
// WRITE | bus_valid held with stable addr/data until bus_ready
// DONE  | mem_finished high until the producer drops mem_commit
module raster_mem_sink
  import raster_pkg::*;
#(
  parameter int                    DAT_WID        = DEF_DAT_WID,
  parameter int                    BUS_DATA_WID   = DEF_BUS_DATA_WID,
  parameter int                    BUS_ADDR_WID   = 32,
  parameter int                    PTR_WID        = 10,
  parameter logic [BUS_ADDR_WID-1:0] BASE_ADDR    = BUS_ADDR_WID'(32'h4000_0000),
  parameter int                    BYTES_PER_WORD = 4
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic [DAT_WID-1:0]      data,
  input  logic                    mem_commit,
  output logic                    mem_finished,
  input  logic                    clear,
  input  logic [PTR_WID-1:0]      rd_ptr,
  output logic [PTR_WID-1:0]      wr_ptr,
  output logic [PTR_WID:0]        words_avail,
  output logic                    full,
  output logic                    overflow,
  output logic [BUS_ADDR_WID-1:0] bus_addr,
  output logic [BUS_DATA_WID-1:0] bus_data,
  output logic                    bus_valid,
  input  logic                    bus_ready
);

  state_t                    state;
  logic                      clr;
  logic                      inc;
  logic [PTR_WID-1:0]        cap_ptr;
  logic [PTR_WID-1:0]        cap_diff;
  logic                      cap_full;
  logic [BUS_ADDR_WID-1:0]   cap_addr;
  logic [BUS_DATA_WID-1:0]   cap_data;

  // Clear only acts in IDLE; the pointer advances on the bus accept cycle
  always_comb begin
    clr = clear && (state == IDLE);
    inc = (state == WRITE) && bus_ready;
  end

  ring_ptr #(
    .PTR_WID (PTR_WID)
  ) u_ring_ptr (
    .clk         (clk),
    .rst_n       (rst_L),
    .clear       (clr),
    .inc         (inc),
    .rd_ptr      (rd_ptr),
    .wr_ptr      (wr_ptr),
    .words_avail (words_avail),
    .full        (full)
  );

  // Capture view of the pointer: a same-cycle clear makes the capture use
  // index 0, so fullness and address are re-evaluated against that value.
  always_comb begin
    cap_ptr  = clr ? '0 : wr_ptr;
    cap_diff = cap_ptr - rd_ptr;
    cap_full = (cap_diff == {PTR_WID{1'b1}});
    cap_addr = BASE_ADDR + BUS_ADDR_WID'(cap_ptr) * BUS_ADDR_WID'(BYTES_PER_WORD);
    cap_data = BUS_DATA_WID'($signed(data));
  end

  // Handshake FSM with registered bus and completion outputs
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state        <= IDLE;
      mem_finished <= 1'b0;
      bus_valid    <= 1'b0;
      bus_addr     <= '0;
      bus_data     <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            overflow <= 1'b0;
          end
          if (mem_commit) begin
            if (cap_full) begin
              overflow <= 1'b1;
              state    <= STALL;
            end else begin
              bus_addr  <= cap_addr;
              bus_data  <= cap_data;
              bus_valid <= 1'b1;
              state     <= WRITE;
            end
          end
        end
        STALL: begin
          if (!cap_full) begin
            bus_addr  <= cap_addr;
            bus_data  <= cap_data;
            bus_valid <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (bus_ready) begin
            bus_valid    <= 1'b0;
            mem_finished <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (!mem_commit) begin
            mem_finished <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_mem_sink.sv
// Scoreboard bench for raster_mem_sink with a depth-8 ring.
module tb_raster_mem_sink;

  localparam int          PW   = 3;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic          clk = 1'b0;
  logic          rst_L = 1'b0;
  logic [23:0]   data = '0;
  logic          mem_commit = 1'b0;
  logic          mem_finished;
  logic          clear = 1'b0;
  logic [PW-1:0] rd_ptr = '0;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   words_avail;
  logic          full;
  logic          overflow;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_data;
  logic          bus_valid;
  logic          bus_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int bp_cycles = 0;
  int ready_delay = 0;
  int rdy_cnt = 0;
  logic [PW-1:0] exp_ptr = '0;
  logic [63:0]   exp_q[$];

  logic        bp_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  raster_mem_sink #(
    .DAT_WID        (24),
    .BUS_DATA_WID   (32),
    .BUS_ADDR_WID   (32),
    .PTR_WID        (PW),
    .BASE_ADDR      (BASE),
    .BYTES_PER_WORD (4)
  ) dut (
    .clk          (clk),
    .rst_L        (rst_L),
    .data         (data),
    .mem_commit   (mem_commit),
    .mem_finished (mem_finished),
    .clear        (clear),
    .rd_ptr       (rd_ptr),
    .wr_ptr       (wr_ptr),
    .words_avail  (words_avail),
    .full         (full),
    .overflow     (overflow),
    .bus_addr     (bus_addr),
    .bus_data     (bus_data),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [23:0] d);
    return {{8{d[23]}}, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [23:0] d);
    logic [31:0] a;
    a = BASE + {29'd0, exp_ptr} * 32'd4;
    exp_q.push_back({a, sext(d)});
    exp_ptr = exp_ptr + 1'b1;
  endtask

  task automatic wait_fin(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_finished) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: mem_finished not seen within 100 cycles", name);
    end
  endtask

  // Full handshake; finished must hold for 'hold' cycles, drop one cycle after commit
  task automatic send(input string name, input logic [23:0] d, input int hold);
    int w0;
    w0 = n_writes;
    push_exp(d);
    step();
    data = d;
    mem_commit = 1'b1;
    wait_fin(name);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_fin_held"}, 64'(mem_finished), 64'd1);
    end
    step();
    mem_commit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_fin_low"}, 64'(mem_finished), 64'd0);
    chk({name, "_one_write"}, 64'(n_writes - w0), 64'd1);
  endtask

  task automatic do_clear();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_ptr = '0;
  endtask

  // Bus responder: delays ready by ready_delay cycles of valid
  always @(posedge clk) begin
    #1;
    if (bus_valid && rdy_cnt < ready_delay) begin
      bus_ready = 1'b0;
      rdy_cnt++;
    end else if (bus_valid) begin
      bus_ready = 1'b1;
    end else begin
      bus_ready = 1'b0;
      rdy_cnt = 0;
    end
  end

  // Monitor: stability under backpressure and scoreboard compare on accept
  always @(negedge clk) begin
    if (rst_L && bp_prev) begin
      chk("bp_valid_stable", 64'(bus_valid), 64'd1);
      chk("bp_addr_stable", 64'(bus_addr), 64'(prev_addr));
      chk("bp_data_stable", 64'(bus_data), 64'(prev_data));
    end
    bp_prev   = rst_L && bus_valid && !bus_ready;
    prev_addr = bus_addr;
    prev_data = bus_data;
    if (bp_prev) bp_cycles++;
    if (rst_L && bus_valid && bus_ready) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {bus_addr, bus_data}, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus_addr), 64'(e[63:32]));
        chk("wr_data", 64'(bus_data), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int bp0;
    repeat (2) @(negedge clk);
    chk("rst_finished", 64'(mem_finished), 64'd0);
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_data", 64'(bus_data), 64'd0);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    step();
    rst_L = 1'b1;
    step();

    // Single word, minimum latency
    push_exp(24'h800001);
    step();
    data = 24'h800001;
    mem_commit = 1'b1;
    @(negedge clk);
    chk("t0_valid", 64'(bus_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid", 64'(bus_valid), 64'd1);
    chk("t1_addr", 64'(bus_addr), 64'(BASE));
    chk("t1_data", 64'(bus_data), 64'h0000_0000_FF80_0001);
    chk("t1_fin", 64'(mem_finished), 64'd0);
    @(negedge clk);
    chk("t2_fin", 64'(mem_finished), 64'd1);
    @(negedge clk);
    chk("t3_fin_held", 64'(mem_finished), 64'd1);
    step();
    mem_commit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("single_fin_low", 64'(mem_finished), 64'd0);
    chk("single_wr_ptr", 64'(wr_ptr), 64'd1);
    chk("single_avail", 64'(words_avail), 64'd1);

    // Backpressure: five cycles of ready low
    ready_delay = 5;
    bp0 = bp_cycles;
    send("bp", 24'h123456, 1);
    chk("bp_cycles", 64'(bp_cycles - bp0), 64'd5);
    ready_delay = 0;
    chk("bp_wr_ptr", 64'(wr_ptr), 64'd2);

    // Wrap with the kernel keeping up
    do_clear();
    step();
    rd_ptr = '0;
    chk("clr_wr_ptr", 64'(wr_ptr), 64'd0);
    for (int i = 0; i < 8; i++) begin
      send("wrap", 24'h000100 + 24'(i), 1);
      step();
      rd_ptr = exp_ptr;
    end
    chk("wrap_wr_ptr", 64'(wr_ptr), 64'd0);
    send("wrap_base", 24'h7ABCDE, 1);
    chk("wrap_overflow", 64'(overflow), 64'd0);

    // Full stall and release by the kernel
    do_clear();
    step();
    rd_ptr = '0;
    for (int i = 0; i < 7; i++) send("fill", 24'hF00000 + 24'(i), 1);
    @(negedge clk);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_avail", 64'(words_avail), 64'd7);
    w0 = n_writes;
    push_exp(24'h7FFFFF);
    step();
    data = 24'h7FFFFF;
    mem_commit = 1'b1;
    repeat (4) @(negedge clk);
    chk("stall_overflow", 64'(overflow), 64'd1);
    chk("stall_valid", 64'(bus_valid), 64'd0);
    chk("stall_fin", 64'(mem_finished), 64'd0);
    chk("stall_no_write", 64'(n_writes - w0), 64'd0);
    step();
    rd_ptr = 3'd1;
    wait_fin("stall");
    chk("stall_one_write", 64'(n_writes - w0), 64'd1);
    step();
    mem_commit = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("stall_ovf_sticky", 64'(overflow), 64'd1);
    step();
    rd_ptr = '0;

    // Commit held long after finished
    send("held", 24'h00ABCD, 10);
    chk("held_wr_ptr", 64'(wr_ptr), 64'd1);

    // Reset while a write is pending
    ready_delay = 20;
    step();
    data = 24'h555555;
    mem_commit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_valid) break;
    end
    chk("pre_rst_valid", 64'(bus_valid), 64'd1);
    #2;
    rst_L = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus_valid), 64'd0);
    chk("mid_rst_fin", 64'(mem_finished), 64'd0);
    chk("mid_rst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    step();
    mem_commit = 1'b0;
    ready_delay = 0;
    exp_ptr = '0;
    rst_L = 1'b1;
    step();

    // Clear and commit in the same cycle: capture uses index 0
    send("pre_clr", 24'h0F0F0F, 1);
    chk("pre_clr_wr_ptr", 64'(wr_ptr), 64'd1);
    exp_ptr = '0;
    push_exp(24'hC00000);
    step();
    clear = 1'b1;
    data = 24'hC00000;
    mem_commit = 1'b1;
    step();
    clear = 1'b0;
    wait_fin("clr_commit");
    step();
    mem_commit = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_commit_wr_ptr", 64'(wr_ptr), 64'd1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
